pre_spike_hist_reader: RTL and testbench

Read-side counterpart of the pre-synaptic spike-history writer. Each pre-neuron SRAM word is a bitmap; bit t set means that neuron spiked at time step t. On a learning-phase start, this block scans the pre-neuron SRAM address by address and decodes each bitmap into a spike count and first-spike step. It streams results to the weight-update logic over a valid/ready handshake, and can optionally clear each word after reading it.

---
 rtl/pre_spike_hist_reader_pkg.sv | 17 +
 rtl/pre_spike_hist_reader_decode.sv | 29 ++
 rtl/pre_spike_hist_reader.sv | 130 +++++++++++++
 tb/tb_pre_spike_hist_reader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pre_spike_hist_reader_pkg.sv
// Shared definitions for the pre-synaptic spike-history reader and writer sides.
package pre_spike_hist_reader_pkg;

   localparam int unsigned TIME_STEP_DEF = 8;
   localparam int unsigned N_DEF         = 256;
   localparam int unsigned M_DEF         = 8;
   localparam int unsigned CNT_W         = $clog2(TIME_STEP_DEF + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CAP,
      ST_OUT,
      ST_DONE
   } state_e;

endpackage

// File: rtl/pre_spike_hist_reader_decode.sv
// Combinational spike-bitmap decoder: popcount, lowest set bit, any-spike flag.
module spike_bitmap_decode
   import pre_spike_hist_reader_pkg::*;
#(
   parameter int unsigned TIME_STEP = TIME_STEP_DEF,
   parameter int unsigned CNT_WIDTH = $clog2(TIME_STEP + 1),
   parameter int unsigned FIRST_W   = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1
) (
   input  logic [TIME_STEP-1:0] bitmap_i,
   output logic [CNT_WIDTH-1:0] count_o,
   output logic [FIRST_W-1:0]   first_o,
   output logic                 any_o
);

   always_comb begin
      count_o = '0;
      first_o = '0;
      // Scanning downward lets the lowest set bit overwrite any higher one.
      for (int unsigned i = TIME_STEP; i > 0; i--) begin
         count_o = count_o + CNT_WIDTH'(bitmap_i[i-1]);
         if (bitmap_i[i-1]) begin
            first_o = FIRST_W'(i - 1);
         end
      end
   end

   assign any_o = |bitmap_i;

endmodule

// File: rtl/pre_spike_hist_reader.sv
// Scans the pre-neuron spike-history SRAM, decodes each bitmap and streams the
// results over valid/ready, optionally clearing each word after it is read.
module pre_spike_hist_reader
   import pre_spike_hist_reader_pkg::*;
#(
   parameter int unsigned PRE_NEUR_SPIKE_CNT_WIDTH = 8,
   parameter int unsigned TIME_STEP                = TIME_STEP_DEF,
   parameter int unsigned N                        = N_DEF,
   parameter int unsigned M                        = M_DEF,
   parameter int unsigned CNT_WIDTH                = $clog2(TIME_STEP + 1),
   parameter int unsigned FIRST_W                  = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1
) (
   input  logic                                CLK,
   input  logic                                RST_N,
   input  logic                                start,
   input  logic                                clear_en,
   input  logic                                abort,
   output logic                                sram_cs,
   output logic                                sram_we,
   output logic [M-1:0]                        sram_addr,
   output logic [PRE_NEUR_SPIKE_CNT_WIDTH-1:0] sram_wdata,
   input  logic [PRE_NEUR_SPIKE_CNT_WIDTH-1:0] sram_rdata,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [M-1:0]                        out_addr,
   output logic [TIME_STEP-1:0]                out_bitmap,
   output logic [CNT_WIDTH-1:0]                out_count,
   output logic [FIRST_W-1:0]                  out_first,
   output logic                                out_any,
   output logic                                busy,
   output logic                                done
);

   localparam logic [M-1:0] LAST_ADDR = M'(N - 1);

   state_e               state_q, state_d;
   logic [M-1:0]         addr_q, addr_d;
   logic                 clr_q, clr_d;
   logic [TIME_STEP-1:0] bitmap_q, bitmap_d;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         clr_q    <= 1'b0;
         bitmap_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         clr_q    <= clr_d;
         bitmap_q <= bitmap_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      clr_d     = clr_q;
      bitmap_d  = bitmap_q;
      sram_cs   = 1'b0;
      sram_we   = 1'b0;
      sram_addr = '0;
      out_valid = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               clr_d   = clear_en;
               addr_d  = '0;
               state_d = ST_RD;
            end
         end
         ST_RD: begin
            sram_cs   = 1'b1;
            sram_addr = addr_q;
            state_d   = ST_CAP;
         end
         ST_CAP: begin
            bitmap_d = sram_rdata[TIME_STEP-1:0];
            if (clr_q) begin
               sram_cs   = 1'b1;
               sram_we   = 1'b1;
               sram_addr = addr_q;
            end
            state_d = ST_OUT;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (addr_q == LAST_ADDR) begin
                  state_d = ST_DONE;
               end else begin
                  addr_d  = addr_q + M'(1);
                  state_d = ST_RD;
               end
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort overrides any accept decided above, so the address does not advance.
      if (abort && (state_q != ST_IDLE)) begin
         state_d  = ST_IDLE;
         addr_d   = addr_q;
         bitmap_d = bitmap_q;
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign sram_wdata = '0;
   assign out_addr   = addr_q;
   assign out_bitmap = bitmap_q;

   spike_bitmap_decode #(
      .TIME_STEP (TIME_STEP),
      .CNT_WIDTH (CNT_WIDTH),
      .FIRST_W   (FIRST_W)
   ) u_decode (
      .bitmap_i (bitmap_q),
      .count_o  (out_count),
      .first_o  (out_first),
      .any_o    (out_any)
   );

endmodule

// File: tb/tb_pre_spike_hist_reader.sv
// Directed bench for pre_spike_hist_reader: decode table, clear-on-read,
// backpressure, abort, mid-scan reset and ignored high bitmap bits.
module tb_pre_spike_hist_reader;

   typedef struct {
      logic [7:0] word;
      logic [7:0] bm;
      logic [3:0] cnt;
      logic [2:0] first;
      logic       any;
   } vec_t;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       start = 1'b0, clear_en = 1'b0, abort = 1'b0, out_ready = 1'b0;
   logic       sram_cs, sram_we;
   logic [1:0] sram_addr;
   logic [7:0] sram_wdata, sram_rdata;
   logic       out_valid, out_any, busy, done;
   logic [1:0] out_addr;
   logic [7:0] out_bitmap;
   logic [3:0] out_count;
   logic [2:0] out_first;

   logic       start2 = 1'b0, ready2 = 1'b0;
   logic       cs2, we2, valid2, any2, busy2, done2;
   logic [0:0] addr2, oaddr2;
   logic [9:0] wdata2, rdata2;
   logic [7:0] bm2;
   logic [3:0] cnt2;
   logic [2:0] first2;

   int n_tests = 0;
   int n_fail  = 0;

   vec_t       tbl [4];
   logic [7:0] mem [4];
   logic [7:0] img [4];
   logic       load = 1'b0;
   int         wr_cnt = 0;

   always #5 CLK = ~CLK;

   pre_spike_hist_reader #(
      .PRE_NEUR_SPIKE_CNT_WIDTH (8),
      .TIME_STEP                (8),
      .N                        (4),
      .M                        (2)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .clear_en(clear_en), .abort(abort),
      .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_bitmap(out_bitmap), .out_count(out_count), .out_first(out_first),
      .out_any(out_any), .busy(busy), .done(done)
   );

   pre_spike_hist_reader #(
      .PRE_NEUR_SPIKE_CNT_WIDTH (10),
      .TIME_STEP                (8),
      .N                        (2),
      .M                        (1)
   ) dut_wide (
      .CLK(CLK), .RST_N(RST_N), .start(start2), .clear_en(1'b0), .abort(1'b0),
      .sram_cs(cs2), .sram_we(we2), .sram_addr(addr2),
      .sram_wdata(wdata2), .sram_rdata(rdata2),
      .out_valid(valid2), .out_ready(ready2), .out_addr(oaddr2),
      .out_bitmap(bm2), .out_count(cnt2), .out_first(first2),
      .out_any(any2), .busy(busy2), .done(done2)
   );

   always @(posedge CLK) begin
      if (load) begin
         for (int i = 0; i < 4; i++) mem[i] <= img[i];
         wr_cnt <= 0;
      end else if (sram_cs && sram_we) begin
         mem[sram_addr] <= sram_wdata;
         wr_cnt <= wr_cnt + 1;
      end else if (sram_cs) begin
         sram_rdata <= mem[sram_addr];
      end
   end

   always @(posedge CLK) begin
      if (cs2 && !we2) rdata2 <= (addr2 == 1'b0) ? 10'h3FF : 10'h300;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic load_table();
      for (int i = 0; i < 4; i++) img[i] = tbl[i].word;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic wait_valid_addr(input logic [1:0] a, input string tag);
      bit ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (out_valid && out_addr == a) ok = 1;
         else tick();
      end
      check({tag, " wait valid"}, 32'(ok), 32'd1);
   endtask

   task automatic wait_done(input string tag);
      bit ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         if (done) ok = 1;
         tick();
      end
      check({tag, " wait done"}, 32'(ok), 32'd1);
   endtask

   // Full scan with out_ready high; checks every cycle against the table.
   task automatic run_scan(input bit clr, input bit zeros, input string tag);
      out_ready = 1'b1;
      clear_en  = clr;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      clear_en  = 1'b0;
      for (int cyc = 1; cyc <= 14; cyc++) begin
         automatic int  ph  = cyc % 3;
         automatic bit  v   = (cyc >= 3) && (cyc <= 12) && (ph == 0);
         automatic int  idx;
         check($sformatf("%s c%0d valid", tag, cyc), 32'(out_valid), 32'(v));
         check($sformatf("%s c%0d done", tag, cyc), 32'(done), 32'(cyc == 13));
         if (ph == 1 && cyc <= 10) begin
            idx = (cyc - 1) / 3;
            check($sformatf("%s c%0d rd cs/we/addr", tag, cyc),
                  {sram_cs, sram_we, 2'(sram_addr)}, {1'b1, 1'b0, 2'(idx)});
         end else if (ph == 2 && cyc <= 11) begin
            idx = (cyc - 2) / 3;
            check($sformatf("%s c%0d cap cs/we", tag, cyc),
                  {sram_cs, sram_we}, {clr, clr});
            if (clr) check($sformatf("%s c%0d clr addr", tag, cyc), 32'(sram_addr), 32'(idx));
         end else begin
            check($sformatf("%s c%0d idle sram", tag, cyc), 32'(sram_cs), 32'd0);
         end
         if (v) begin
            idx = cyc / 3 - 1;
            check($sformatf("%s r%0d addr", tag, idx), 32'(out_addr), 32'(idx));
            check($sformatf("%s r%0d bitmap", tag, idx), 32'(out_bitmap), zeros ? 0 : 32'(tbl[idx].bm));
            check($sformatf("%s r%0d count", tag, idx), 32'(out_count), zeros ? 0 : 32'(tbl[idx].cnt));
            check($sformatf("%s r%0d first", tag, idx), 32'(out_first), zeros ? 0 : 32'(tbl[idx].first));
            check($sformatf("%s r%0d any", tag, idx), 32'(out_any), zeros ? 0 : 32'(tbl[idx].any));
         end
         tick();
      end
      check({tag, " busy after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{word: 8'h00, bm: 8'h00, cnt: 4'd0, first: 3'd0, any: 1'b0};
      tbl[1] = '{word: 8'h01, bm: 8'h01, cnt: 4'd1, first: 3'd0, any: 1'b1};
      tbl[2] = '{word: 8'h80, bm: 8'h80, cnt: 4'd1, first: 3'd7, any: 1'b1};
      tbl[3] = '{word: 8'hA5, bm: 8'hA5, cnt: 4'd4, first: 3'd0, any: 1'b1};

      // Reset state
      #12;
      check("rst cs/we/valid/busy/done", {sram_cs, sram_we, out_valid, busy, done}, 5'b0);
      check("rst out fields", {out_addr, out_bitmap, out_count, out_first, out_any}, '0);
      RST_N = 1'b1;
      tick();
      load_table();

      run_scan(1'b0, 1'b0, "decode");
      check("decode no writes", 32'(wr_cnt), 32'd0);

      // Clear-on-read, then a rescan must see only zeros
      run_scan(1'b1, 1'b0, "clear");
      check("clear write count", 32'(wr_cnt), 32'd4);
      for (int i = 0; i < 4; i++) check($sformatf("clear mem%0d", i), 32'(mem[i]), 32'd0);
      run_scan(1'b0, 1'b1, "rescan");

      // Backpressure on addr 2, with an ignored start during the stall
      load_table();
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid_addr(2'd2, "bp");
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         start = (i == 1);
         check($sformatf("bp s%0d valid", i), 32'(out_valid), 32'd1);
         check($sformatf("bp s%0d fields", i), {out_addr, out_bitmap, out_count, out_first},
               {2'd2, 8'h80, 4'd1, 3'd7});
         check($sformatf("bp s%0d no sram", i), 32'(sram_cs), 32'd0);
         tick();
      end
      start = 1'b0;
      check("bp still held", {out_valid, out_addr}, {1'b1, 2'd2});
      out_ready = 1'b1;
      tick();
      check("bp rd addr3", {sram_cs, sram_we, sram_addr}, {1'b1, 1'b0, 2'd3});
      wait_done("bp");

      // Abort in OUT of addr 1 with out_ready high
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid_addr(2'd1, "abort");
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort idle", {busy, out_valid, done, sram_cs}, 4'b0);
      check("abort addr held", 32'(out_addr), 32'd1);
      tick();
      check("abort no done", {done, busy}, 2'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort in idle", {busy, sram_cs}, 2'b0);
      run_scan(1'b0, 1'b0, "post-abort");

      // Asynchronous reset during RD
      start = 1'b1;
      tick();
      start = 1'b0;
      check("rst-mid rd", {sram_cs, busy}, 2'b11);
      #2 RST_N = 1'b0;
      #1;
      check("rst-mid async", {sram_cs, sram_we, busy, out_valid, done}, 5'b0);
      check("rst-mid fields", {out_addr, out_bitmap, out_count, out_first, out_any}, '0);
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
      run_scan(1'b0, 1'b0, "post-rst");

      // Wide word: bits above TIME_STEP are ignored
      ready2 = 1'b1;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      tick();
      tick();
      check("wide r0 valid", 32'(valid2), 32'd1);
      check("wide r0 fields", {bm2, cnt2, first2, any2}, {8'hFF, 4'd8, 3'd0, 1'b1});
      tick();
      tick();
      tick();
      check("wide r1 valid/addr", {valid2, oaddr2}, 2'b11);
      check("wide r1 fields", {bm2, cnt2, first2, any2}, {8'h00, 4'd0, 3'd0, 1'b0});
      tick();
      check("wide done", {done2, busy2}, 2'b11);
      tick();
      check("wide idle", {done2, busy2}, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
